aes_byte_loader: RTL and testbench

Byte-serial loader that assembles the 128-bit AES input block and the 128/192/256-bit cipher key from an 8-bit valid/ready stream. It feeds the `Encrypt`/`Decrypt` cores and `keyExpansion`, and replaces the hard-wired state and key constants. It is the input-side counterpart of the byte-wide result path (`out_main[7:0]` → `Encoder` → `Decoder`). Byte order is MSB first, matching FIPS-197 hex strings as written.

---
 rtl/aes_byte_loader.sv | 133 +++++++++++++
 tb/tb_aes_byte_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_loader.sv
// aes_byte_loader: byte-serial loader for the AES input block and key.
// Bytes arrive MSB first; the key is right-aligned in a 256-bit field.
module aes_byte_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   key_size,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] state_out,
  output logic [255:0] key_out,
  output logic [3:0]   nk_out,
  output logic         busy,
  output logic         loaded,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_STATE,
    LOAD_KEY,
    DONE
  } st_e;

  st_e          st_q;
  logic [127:0] state_q;
  logic [255:0] key_q;
  logic [3:0]   nk_q;
  logic [4:0]   cnt_q;
  logic         loaded_q;
  logic         done_q;
  logic         err_q;

  logic [3:0]   nk_d;
  logic         rsv_d;
  logic         xfer;
  logic         state_last;
  logic         key_last;
  logic [5:0]   key_bytes;

  // Decode the requested key length into nk; 11 is reserved.
  always_comb begin
    nk_d  = 4'd4;
    rsv_d = 1'b0;
    unique case (1'b1)
      (key_size == 2'b00): nk_d = 4'd4;
      (key_size == 2'b01): nk_d = 4'd6;
      (key_size == 2'b10): nk_d = 4'd8;
      default:             rsv_d = 1'b1;
    endcase
  end

  assign in_ready = (st_q == LOAD_STATE) || (st_q == LOAD_KEY);
  assign busy     = in_ready;
  assign xfer     = in_valid && in_ready;

  assign key_bytes  = {nk_q, 2'b00};
  assign state_last = (cnt_q == 5'd15);
  assign key_last   = ({1'b0, cnt_q} == (key_bytes - 6'd1));

  // Load sequencer: owns every registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      nk_q     <= 4'd4;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (start) begin
            if (rsv_d) begin
              err_q <= 1'b1;
            end else begin
              nk_q     <= nk_d;
              state_q  <= '0;
              key_q    <= '0;
              loaded_q <= 1'b0;
              cnt_q    <= '0;
              st_q     <= LOAD_STATE;
            end
          end
        end
        LOAD_STATE: begin
          if (xfer) begin
            state_q <= {state_q[119:0], in_byte};
            if (state_last) begin
              cnt_q <= '0;
              st_q  <= LOAD_KEY;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        LOAD_KEY: begin
          if (xfer) begin
            key_q <= {key_q[247:0], in_byte};
            if (key_last) begin
              cnt_q    <= '0;
              done_q   <= 1'b1;
              loaded_q <= 1'b1;
              st_q     <= DONE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        DONE: begin
          st_q <= IDLE;
        end
        default: begin
          st_q <= IDLE;
        end
      endcase
    end
  end

  assign state_out = state_q;
  assign key_out   = key_q;
  assign nk_out    = nk_q;
  assign loaded    = loaded_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// tb_aes_byte_loader: randomized bench for aes_byte_loader.
// Expected block/key are packed from byte arrays by position.
module tb_aes_byte_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   key_size = 2'b00;
  logic         start = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_out;
  logic [255:0] key_out;
  logic [3:0]   nk_out;
  logic         busy;
  logic         loaded;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[16];
  logic [7:0] kb[32];

  aes_byte_loader dut (
    .clk(clk), .rst_n(rst_n), .key_size(key_size), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .state_out(state_out), .key_out(key_out), .nk_out(nk_out),
    .busy(busy), .loaded(loaded), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int nk_of(input logic [1:0] ks);
    return (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
  endfunction

  function automatic logic [127:0] exp_state();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[i];
    return r;
  endfunction

  function automatic logic [255:0] exp_key(input int nk);
    logic [255:0] r;
    int n;
    r = '0;
    n = 4 * nk;
    for (int i = 0; i < n; i++) r[8*(n-1-i) +: 8] = kb[i];
    return r;
  endfunction

  task automatic rand_bytes();
    for (int i = 0; i < 16; i++) sb[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) kb[i] = 8'($urandom);
  endtask

  // Source side: honours in_ready, optional gaps, optional stray start.
  task automatic run_load(input logic [1:0] ks, input int gap,
                          input int tail, input bit poke,
                          output int lat, output int ndone,
                          output bit early, output bit tmo);
    int total;
    int idx;
    int cyc;
    bit v;
    total = 16 + 4 * nk_of(ks);
    idx = 0; cyc = 0; lat = -1; ndone = 0; early = 0; tmo = 0;
    @(posedge clk); #1;
    key_size = ks; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_size = 2'($urandom);
    forever begin
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end else if (loaded && ndone == 0) begin
        early = 1;
      end
      if (lat >= 0 && cyc >= lat + tail) break;
      if (cyc >= 400) begin tmo = 1; break; end
      v = (idx < total);
      if (gap == 1 && (cyc % 3) == 2) v = 0;
      if (gap == 2 && $urandom_range(3) == 0) v = 0;
      in_valid = v;
      if (v) in_byte = (idx < 16) ? sb[idx] : kb[idx-16];
      else   in_byte = 8'($urandom);
      start = poke && idx >= 20 && idx < 22;
      if (v && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (state_out !== 128'h0 || key_out !== 256'h0) begin
      errors++;
      $display("FAIL reset_data: state %h key %h want 0", state_out, key_out);
    end
    checks++;
    if (nk_out !== 4'd4) begin
      errors++;
      $display("FAIL reset_nk: got %0d want 4", nk_out);
    end
    checks++;
    if ({in_ready, busy, loaded, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {in_ready, busy, loaded, done, err});
    end
    rst_n = 1'b1; in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_load128();
    int lat, nd; bit early, tmo;
    for (int i = 0; i < 16; i++) sb[i] = 8'(8'h11 * i);
    for (int i = 0; i < 32; i++) kb[i] = 8'(i);
    run_load(2'b00, 0, 3, 0, lat, nd, early, tmo);
    checks++;
    if (tmo || lat != 32 || nd != 1) begin
      errors++;
      $display("FAIL load128_done: tmo %0d lat %0d n %0d want 0 32 1",
               tmo, lat, nd);
    end
    checks++;
    if (state_out !== 128'h00112233445566778899aabbccddeeff) begin
      errors++;
      $display("FAIL load128_state: got %h", state_out);
    end
    checks++;
    if (key_out !== {128'h0, 128'h000102030405060708090a0b0c0d0e0f}) begin
      errors++;
      $display("FAIL load128_key: got %h", key_out);
    end
    checks++;
    if (nk_out !== 4'd4 || loaded !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load128_flags: nk %0d loaded %b busy %b want 4 1 0",
               nk_out, loaded, busy);
    end
  endtask

  task automatic test_load256_gaps();
    int lat, nd; bit early, tmo;
    rand_bytes();
    for (int i = 0; i < 32; i++) kb[i] = 8'(i);
    run_load(2'b10, 1, 3, 0, lat, nd, early, tmo);
    checks++;
    if (tmo || nd != 1 || lat <= 48) begin
      errors++;
      $display("FAIL load256_done: tmo %0d lat %0d n %0d want 0 >48 1",
               tmo, lat, nd);
    end
    checks++;
    if (key_out !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f) begin
      errors++;
      $display("FAIL load256_key: got %h", key_out);
    end
    checks++;
    if (state_out !== exp_state() || nk_out !== 4'd8) begin
      errors++;
      $display("FAIL load256_state: got %h nk %0d want %h 8",
               state_out, nk_out, exp_state());
    end
  endtask

  task automatic test_load192();
    int lat, nd; bit early, tmo;
    rand_bytes();
    for (int i = 0; i < 32; i++) kb[i] = 8'(i);
    run_load(2'b01, 0, 3, 0, lat, nd, early, tmo);
    checks++;
    if (tmo || lat != 40 || nd != 1) begin
      errors++;
      $display("FAIL load192_done: tmo %0d lat %0d n %0d want 0 40 1",
               tmo, lat, nd);
    end
    checks++;
    if (key_out !== {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617}) begin
      errors++;
      $display("FAIL load192_key: got %h", key_out);
    end
    checks++;
    if (state_out !== exp_state() || nk_out !== 4'd6) begin
      errors++;
      $display("FAIL load192_state: got %h nk %0d", state_out, nk_out);
    end
  endtask

  task automatic test_reserved();
    @(posedge clk); #1;
    key_size = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsv_err: err %b ready %b busy %b want 1 0 0",
               err, in_ready, busy);
    end
    checks++;
    if (state_out !== exp_state() || key_out !== exp_key(6) ||
        nk_out !== 4'd6 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL rsv_hold: state %h key %h nk %0d loaded %b",
               state_out, key_out, nk_out, loaded);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rsv_pulse: err %b ready %b want 0 0", err, in_ready);
    end
  endtask

  task automatic test_reset_midload();
    int lat, nd; bit early, tmo;
    @(posedge clk); #1;
    key_size = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || state_out !== 128'h0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: busy %b state %h loaded %b",
               busy, state_out, loaded);
    end
    rand_bytes();
    run_load(2'b00, 2, 3, 0, lat, nd, early, tmo);
    checks++;
    if (tmo || nd != 1 || early) begin
      errors++;
      $display("FAIL midrst_done: tmo %0d n %0d early %0d want 0 1 0",
               tmo, nd, early);
    end
    checks++;
    if (state_out !== exp_state() || key_out !== exp_key(4)) begin
      errors++;
      $display("FAIL midrst_data: state %h key %h", state_out, key_out);
    end
  endtask

  task automatic test_ignored();
    int lat, nd; bit early, tmo; bit rdy_seen;
    logic [1:0] ks;
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_byte = 8'($urandom);
      @(posedge clk); #1;
      if (in_ready) rdy_seen = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL idle_ready: got 1 want 0");
    end
    rand_bytes();
    ks = 2'($urandom_range(2));
    run_load(ks, 2, 3, 1, lat, nd, early, tmo);
    checks++;
    if (tmo || nd != 1) begin
      errors++;
      $display("FAIL poke_done: tmo %0d n %0d want 0 1", tmo, nd);
    end
    checks++;
    if (state_out !== exp_state() || key_out !== exp_key(nk_of(ks)) ||
        nk_out !== 4'(nk_of(ks))) begin
      errors++;
      $display("FAIL poke_data: state %h key %h nk %0d", state_out, key_out,
               nk_out);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (state_out !== exp_state() || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop: state %h busy %b", state_out, busy);
    end
  endtask

  task automatic test_random();
    int lat, nd; bit early, tmo;
    logic [1:0] ks;
    for (int t = 0; t < 6; t++) begin
      rand_bytes();
      ks = 2'($urandom_range(2));
      run_load(ks, 2, 2, 0, lat, nd, early, tmo);
      checks++;
      if (tmo || nd != 1 || early || lat < 16 + 4 * nk_of(ks) ||
          state_out !== exp_state() || key_out !== exp_key(nk_of(ks)) ||
          nk_out !== 4'(nk_of(ks))) begin
        errors++;
        $display("FAIL rand_%0d: ks %0d lat %0d n %0d state %h key %h nk %0d",
                 t, ks, lat, nd, state_out, key_out, nk_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd; bit early, tmo;
    rand_bytes();
    run_load(2'b00, 0, 0, 0, lat, nd, early, tmo);
    checks++;
    if (tmo || lat != 32 || state_out !== exp_state() ||
        key_out !== exp_key(4)) begin
      errors++;
      $display("FAIL b2b_first: tmo %0d lat %0d state %h", tmo, lat,
               state_out);
    end
    rand_bytes();
    run_load(2'b10, 0, 3, 0, lat, nd, early, tmo);
    checks++;
    if (tmo || lat != 48 || nd != 1) begin
      errors++;
      $display("FAIL b2b_second: tmo %0d lat %0d n %0d want 0 48 1",
               tmo, lat, nd);
    end
    checks++;
    if (state_out !== exp_state() || key_out !== exp_key(8)) begin
      errors++;
      $display("FAIL b2b_data: state %h key %h", state_out, key_out);
    end
  endtask

  initial begin
    test_reset();
    test_load128();
    test_load256_gaps();
    test_load192();
    test_reserved();
    test_reset_midload();
    test_ignored();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
